// File: rtl/fish_school_engine.sv
// Multi-sprite fish scene: per-fish motion, LFSR respawn, catch-zone counting
// and a one-clock registered pixel renderer, all on the pixel clock.
module fish_school_engine #(
  parameter int          NUM_FISH   = 4,
  parameter int          FISH_W     = 10,
  parameter int          FISH_H     = 5,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          SPEED_BASE = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          NET_X0     = 300,
  parameter int          NET_X1     = 380,
  parameter int          NET_Y0     = 370,
  parameter int          NET_Y1     = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       video_active,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pause,
  input  logic       catch_en,
  output logic       fish_on,
  output logic [2:0] fish_idx,
  output logic [5:0] fish_rgb,
  output logic [7:0] catch_count
);

  localparam int          YLIM = V_ACTIVE - FISH_H;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [9:0] speed(input int i);
    return 10'(SPEED_BASE + (i % 4));
  endfunction

  function automatic logic [9:0] init_x(input int i);
    return 10'(H_ACTIVE - i * (H_ACTIVE / NUM_FISH));
  endfunction

  function automatic logic [9:0] init_y(input int i);
    return 10'(40 + i * ((V_ACTIVE - 80) / NUM_FISH));
  endfunction

  // Each fish sees the LFSR through its own rotation so simultaneous respawns differ.
  function automatic logic [9:0] respawn_y(input logic [15:0] s, input int i);
    int          sh;
    logic [15:0] rot;
    logic [9:0]  r;
    sh  = (3 * i) % 16;
    rot = (sh == 0) ? s : ((s << sh) | (s >> (16 - sh)));
    r   = {1'b0, rot[8:0]};
    if (r < 10'(YLIM))
      return r;
    else
      return r - 10'(YLIM);
  endfunction

  function automatic logic in_net(input logic [9:0] x, input logic [9:0] y);
    logic [10:0] xe;
    logic [10:0] ye;
    xe = {1'b0, x} + 11'(FISH_W);
    ye = {1'b0, y} + 11'(FISH_H);
    return ({1'b0, x} < 11'(NET_X1)) && (xe > 11'(NET_X0)) &&
           ({1'b0, y} < 11'(NET_Y1)) && (ye > 11'(NET_Y0));
  endfunction

  function automatic logic in_rect(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] x,  input logic [9:0] y);
    logic [10:0] xe;
    logic [10:0] ye;
    xe = {1'b0, x} + 11'(FISH_W);
    ye = {1'b0, y} + 11'(FISH_H);
    return (px >= x) && ({1'b0, px} < xe) && (py >= y) && ({1'b0, py} < ye);
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [3:0] n);
    logic [8:0] s;
    s = {1'b0, c} + {5'b00000, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [5:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    return 6'b110111;
      2'd1:    return 6'b111100;
      2'd2:    return 6'b011111;
      default: return 6'b110011;
    endcase
  endfunction

  logic                vsync_q;
  logic                frame_tick;
  logic                do_update;
  logic [15:0]         lfsr;
  logic [9:0]          fish_x [NUM_FISH];
  logic [9:0]          fish_y [NUM_FISH];
  logic [9:0]          nxt_x  [NUM_FISH];
  logic [9:0]          nxt_y  [NUM_FISH];
  logic [NUM_FISH-1:0] caught;
  logic [3:0]          n_caught;
  logic [NUM_FISH-1:0] hit;
  logic [2:0]          hit_idx;

  assign frame_tick = vsync & ~vsync_q;
  assign do_update  = frame_tick & ~pause;

  always_comb begin : motion
    n_caught = 4'd0;
    for (int i = 0; i < NUM_FISH; i++) begin
      nxt_x[i]  = fish_x[i] - speed(i);
      nxt_y[i]  = fish_y[i];
      caught[i] = catch_en && in_net(fish_x[i], fish_y[i]);
      if (caught[i] || (fish_x[i] <= speed(i))) begin
        nxt_x[i] = 10'(H_ACTIVE);
        nxt_y[i] = respawn_y(lfsr, i);
      end
      n_caught = n_caught + {3'b000, caught[i]};
    end
  end

  // Lowest index wins, so scan from the top down.
  always_comb begin : render
    hit_idx = 3'd0;
    for (int i = 0; i < NUM_FISH; i++)
      hit[i] = in_rect(pix_x, pix_y, fish_x[i], fish_y[i]);
    for (int i = NUM_FISH - 1; i >= 0; i--)
      if (hit[i]) hit_idx = 3'(i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q     <= 1'b1;
      lfsr        <= SEED;
      catch_count <= 8'd0;
      fish_on     <= 1'b0;
      fish_idx    <= 3'd0;
      fish_rgb    <= 6'd0;
      for (int i = 0; i < NUM_FISH; i++) begin
        fish_x[i] <= init_x(i);
        fish_y[i] <= init_y(i);
      end
    end else begin
      vsync_q <= vsync;
      lfsr    <= lfsr_next(lfsr);
      // render stage: pixel sampled this cycle, result visible next cycle
      if (video_active && (|hit)) begin
        fish_on  <= 1'b1;
        fish_idx <= hit_idx;
        fish_rgb <= palette(hit_idx[1:0]);
      end else begin
        fish_on  <= 1'b0;
        fish_idx <= 3'd0;
        fish_rgb <= 6'd0;
      end
      if (do_update) begin
        for (int i = 0; i < NUM_FISH; i++) begin
          fish_x[i] <= nxt_x[i];
          fish_y[i] <= nxt_y[i];
        end
        catch_count <= sat_add(catch_count, n_caught);
      end
    end
  end

endmodule

// File: tb/tb_fish_school_engine.sv
// Bench for fish_school_engine: default instance plus a full-screen-net instance
// (saturation) and a tiny-screen instance (overlapping sprites for priority).
module tb_fish_school_engine;

  logic       clk, reset, vsync, video_active, pause, catch_en;
  logic [9:0] pix_x, pix_y;
  logic       a_on, b_on, c_on;
  logic [2:0] a_idx, b_idx, c_idx;
  logic [5:0] a_rgb, b_rgb, c_rgb;
  logic [7:0] a_cnt, b_cnt, c_cnt;

  fish_school_engine dut_a (
    .clk(clk), .reset(reset), .vsync(vsync), .video_active(video_active),
    .pix_x(pix_x), .pix_y(pix_y), .pause(pause), .catch_en(catch_en),
    .fish_on(a_on), .fish_idx(a_idx), .fish_rgb(a_rgb), .catch_count(a_cnt));

  fish_school_engine #(.NUM_FISH(2), .NET_X0(0), .NET_X1(640), .NET_Y0(0), .NET_Y1(480)) dut_b (
    .clk(clk), .reset(reset), .vsync(vsync), .video_active(video_active),
    .pix_x(pix_x), .pix_y(pix_y), .pause(pause), .catch_en(catch_en),
    .fish_on(b_on), .fish_idx(b_idx), .fish_rgb(b_rgb), .catch_count(b_cnt));

  fish_school_engine #(.NUM_FISH(4), .H_ACTIVE(16), .V_ACTIVE(84)) dut_c (
    .clk(clk), .reset(reset), .vsync(vsync), .video_active(video_active),
    .pix_x(pix_x), .pix_y(pix_y), .pause(pause), .catch_en(catch_en),
    .fish_on(c_on), .fish_idx(c_idx), .fish_rgb(c_rgb), .catch_count(c_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  int          n_chk, n_fail;
  int          mx[4], my[4], mcnt;
  logic [15:0] mlfsr;

  // Reference LFSR for instance A, advanced every clock.
  always @(posedge clk or posedge reset) begin
    if (reset) mlfsr <= 16'hACE1;
    else       mlfsr <= mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_resp_y(input logic [15:0] s, input int i);
    logic [15:0] r;
    int          v;
    r = s;
    for (int k = 0; k < 3 * i; k++) r = {r[14:0], r[15]};
    v = int'(r[8:0]);
    return (v < 475) ? v : v - 475;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 640 - i * 160;
      my[i] = 40 + i * 100;
    end
    mcnt = 0;
  endtask

  task automatic model_tick(input logic [15:0] s);
    int n, spd;
    bit hitnet;
    if (pause) return;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      spd    = 1 + (i % 4);
      hitnet = catch_en && (mx[i] < 380) && (mx[i] + 10 > 300) && (my[i] < 400) && (my[i] + 5 > 370);
      if (hitnet) begin
        n++;
        mx[i] = 640; my[i] = m_resp_y(s, i);
      end else if (mx[i] <= spd) begin
        mx[i] = 640; my[i] = m_resp_y(s, i);
      end else begin
        mx[i] = mx[i] - spd;
      end
    end
    mcnt = (mcnt + n > 255) ? 255 : mcnt + n;
  endtask

  task automatic tick_frame();
    @(negedge clk);
    vsync = 1'b1;
    model_tick(mlfsr);
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_x%0d", tag, i), dut_a.fish_x[i], mx[i]);
      chk($sformatf("%s_y%0d", tag, i), dut_a.fish_y[i], my[i]);
    end
    chk({tag, "_cnt"}, a_cnt, mcnt);
  endtask

  typedef struct {
    int px, py, va;
    int a_on, a_idx, a_rgb;
    int c_on, c_idx, c_rgb;
  } vec_t;

  vec_t        vt[20];
  int          rx[4], ry[4], ex[4], px0[4];
  logic [15:0] lf_snap;
  int          exp_b;

  initial begin
    n_chk = 0; n_fail = 0;
    // Instance C at reset: x = 16,12,8,4  y = 40,41,42,43 (fish 1 and 2 overlap)
    vt[0]  = '{13, 42, 1,  0, 0, 0,   1, 1, 60};
    vt[1]  = '{12, 41, 1,  0, 0, 0,   1, 1, 60};
    vt[2]  = '{13, 43, 1,  0, 0, 0,   1, 1, 60};
    vt[3]  = '{9,  42, 1,  0, 0, 0,   1, 2, 31};
    vt[4]  = '{5,  44, 1,  0, 0, 0,   1, 3, 51};
    vt[5]  = '{17, 40, 1,  0, 0, 0,   1, 0, 55};
    vt[6]  = '{17, 41, 1,  0, 0, 0,   1, 0, 55};
    vt[7]  = '{13, 42, 0,  0, 0, 0,   0, 0, 0};
    vt[8]  = '{30, 60, 1,  0, 0, 0,   0, 0, 0};
    vt[9]  = '{21, 45, 1,  0, 0, 0,   1, 1, 60};
    vt[10] = '{22, 45, 1,  0, 0, 0,   0, 0, 0};
    vt[11] = '{3,  43, 1,  0, 0, 0,   0, 0, 0};
    // Instance A at reset: x = 640,480,320,160  y = 40,140,240,340
    vt[12] = '{320, 240, 1,  1, 2, 31,  0, 0, 0};
    vt[13] = '{329, 244, 1,  1, 2, 31,  0, 0, 0};
    vt[14] = '{330, 244, 1,  0, 0, 0,   0, 0, 0};
    vt[15] = '{320, 245, 1,  0, 0, 0,   0, 0, 0};
    vt[16] = '{160, 340, 1,  1, 3, 51,  0, 0, 0};
    vt[17] = '{480, 140, 1,  1, 1, 60,  0, 0, 0};
    vt[18] = '{480, 140, 0,  0, 0, 0,   0, 0, 0};
    vt[19] = '{639, 40,  1,  0, 0, 0,   0, 0, 0};
    rx = '{640, 480, 320, 160};
    ry = '{40, 140, 240, 340};

    reset = 1'b1; vsync = 1'b0; video_active = 1'b0; pause = 1'b0; catch_en = 1'b0;
    pix_x = 10'd0; pix_y = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_on", a_on, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_rgb", a_rgb, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_lfsr", dut_a.lfsr, 16'hACE1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_x%0d", i), dut_a.fish_x[i], rx[i]);
      chk($sformatf("rst_y%0d", i), dut_a.fish_y[i], ry[i]);
    end
    reset = 1'b0;
    @(negedge clk);

    // Three frames, no catching
    repeat (3) tick_frame();
    ex = '{637, 474, 311, 148};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f3_x%0d", i), dut_a.fish_x[i], ex[i]);
      chk($sformatf("f3_y%0d", i), dut_a.fish_y[i], ry[i]);
    end
    chk("f3_cnt", a_cnt, 0);
    chk_model("f3m");

    // vsync held high for 50 clocks gives one update; the next edge gives another
    @(negedge clk);
    vsync = 1'b1;
    model_tick(mlfsr);
    repeat (50) @(negedge clk);
    chk("hold_x0", dut_a.fish_x[0], 636);
    chk("hold_x3", dut_a.fish_x[3], 144);
    vsync = 1'b0;
    @(negedge clk);
    tick_frame();
    chk("hold2_x0", dut_a.fish_x[0], 635);
    chk("hold2_x3", dut_a.fish_x[3], 140);

    // Drive fish 0 down to x=1, then the edge respawn
    repeat (634) tick_frame();
    chk("edge_pre_x0", dut_a.fish_x[0], 1);
    chk_model("edge_pre");
    tick_frame();
    chk("edge_x0", dut_a.fish_x[0], 640);
    chk("edge_y0", dut_a.fish_y[0], my[0]);
    chk("edge_y0_range", dut_a.fish_y[0] < 475, 1);
    chk("edge_cnt", a_cnt, 0);
    chk("edge_lfsr", dut_a.lfsr, mlfsr);

    // Catching enabled, model tracked frame by frame
    catch_en = 1'b1;
    for (int f = 0; f < 700; f++) begin
      tick_frame();
      chk_model($sformatf("catch%0d", f));
    end
    catch_en = 1'b0;

    // Pause: positions frozen, LFSR keeps running
    for (int i = 0; i < 4; i++) px0[i] = dut_a.fish_x[i];
    lf_snap = mlfsr;
    pause = 1'b1;
    repeat (5) tick_frame();
    pause = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("pause_x%0d", i), dut_a.fish_x[i], px0[i]);
    chk_model("pause");
    chk("pause_lfsr", dut_a.lfsr, mlfsr);
    chk("pause_lfsr_moved", dut_a.lfsr != lf_snap, 1);

    // Render table
    do_reset();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      pix_x = 10'(vt[n].px); pix_y = 10'(vt[n].py); video_active = vt[n].va[0];
      @(negedge clk);
      chk($sformatf("tab%0d_a_on", n), a_on, vt[n].a_on);
      chk($sformatf("tab%0d_a_idx", n), a_idx, vt[n].a_idx);
      chk($sformatf("tab%0d_a_rgb", n), a_rgb, vt[n].a_rgb);
      chk($sformatf("tab%0d_c_on", n), c_on, vt[n].c_on);
      chk($sformatf("tab%0d_c_idx", n), c_idx, vt[n].c_idx);
      chk($sformatf("tab%0d_c_rgb", n), c_rgb, vt[n].c_rgb);
    end

    // One-clock latency
    @(negedge clk);
    pix_x = 10'd320; pix_y = 10'd240; video_active = 1'b1;
    @(posedge clk); #1;
    chk("lat_on", a_on, 1);
    @(negedge clk);
    pix_x = 10'd0; pix_y = 10'd0;
    #4;
    chk("lat_hold", a_on, 1);
    @(posedge clk); #1;
    chk("lat_off", a_on, 0);

    // Reset asserted mid-frame while a fish is being drawn
    repeat (2) tick_frame();
    @(negedge clk);
    pix_x = 10'(mx[2]); pix_y = 10'(my[2]);
    @(negedge clk);
    chk("mid_on_before", a_on, 1);
    chk("mid_idx_before", a_idx, 2);
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk("mid_on", a_on, 0);
    chk("mid_idx", a_idx, 0);
    chk("mid_rgb", a_rgb, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_x%0d", i), dut_a.fish_x[i], rx[i]);
      chk($sformatf("mid_y%0d", i), dut_a.fish_y[i], ry[i]);
    end
    @(negedge clk);
    reset = 1'b0;
    video_active = 1'b0;
    @(negedge clk);
    tick_frame();
    ex = '{639, 478, 317, 156};
    for (int i = 0; i < 4; i++) chk($sformatf("post_x%0d", i), dut_a.fish_x[i], ex[i]);

    // Full-screen net: single catch
    do_reset();
    catch_en = 1'b1;
    tick_frame();
    chk("b_single", b_cnt, 1);

    // Full-screen net: paired catches up to saturation
    do_reset();
    catch_en = 1'b0;
    tick_frame();
    chk("b_idle", b_cnt, 0);
    for (int k = 1; k <= 128; k++) begin
      catch_en = 1'b1;
      tick_frame();
      exp_b = (2 * k > 255) ? 255 : 2 * k;
      chk($sformatf("b_pair%0d", k), b_cnt, exp_b);
      catch_en = 1'b0;
      tick_frame();
    end
    catch_en = 1'b1;
    tick_frame();
    chk("b_sat_hold", b_cnt, 255);
    catch_en = 1'b0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
